ahb_clk_en_gen: RTL and testbench

AHB_CLK_EN_GEN -- requirements
Module: ahb_clk_en_gen

---
 rtl/ahb_clk_en_gen_if.sv | 24 ++
 rtl/ahb_clk_en_gen.sv | 182 ++++++++++++++++++
 tb/tb_ahb_clk_en_gen.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_clk_en_gen_if.sv
// AHB-Lite slave bus bundle for ahb_clk_en_gen; the master modport drives the
// address/data phase inputs and the slave modport returns the response.
interface ahb_clk_en_gen_if;
  logic        i_hselx;
  logic        i_hready;
  logic [1:0]  i_htrans;
  logic        i_hwrite;
  logic [31:0] i_haddr;
  logic [2:0]  i_hsize;
  logic [31:0] i_hwdata;
  logic        o_hreadyout;
  logic        o_hresp;
  logic [31:0] o_hrdata;

  modport master (
    output i_hselx, i_hready, i_htrans, i_hwrite, i_haddr, i_hsize, i_hwdata,
    input  o_hreadyout, o_hresp, o_hrdata
  );

  modport slave (
    input  i_hselx, i_hready, i_htrans, i_hwrite, i_haddr, i_hsize, i_hwdata,
    output o_hreadyout, o_hresp, o_hrdata
  );
endinterface

// File: rtl/ahb_clk_en_gen.sv
// AHB-Lite programmable clock-enable generator: per channel OFF/SETTLE/RUN with a
// lock timer and divided enable pulses. Define CLKEN_IRQ_EN for the lock interrupt.
module ahb_clk_en_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_WIDTH   = 8,
  parameter int LOCK_CYCLES = 16
) (
  input  logic              i_clk_ahb,
  input  logic              i_rst_ahb,
  ahb_clk_en_gen_if.slave   bus,
  output logic [NUM_CH-1:0] o_clk_en,
  output logic [NUM_CH-1:0] o_locked
`ifdef CLKEN_IRQ_EN
  ,
  output logic              o_irq
`endif
);

  localparam logic [7:0] LOCK_INIT = 8'(LOCK_CYCLES);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_SETTLE,
    ST_RUN
  } ch_state_e;

  logic                 addr_valid_q, addr_valid_d;
  logic                 addr_write_q, addr_write_d;
  logic [5:0]           addr_idx_q, addr_idx_d;
  logic [NUM_CH-1:0]    ctrl_q, ctrl_d;
  logic [DIV_WIDTH-1:0] div_q [NUM_CH];
  logic [DIV_WIDTH-1:0] div_d [NUM_CH];
  ch_state_e            state_q [NUM_CH];
  ch_state_e            state_d [NUM_CH];
  logic [7:0]           lock_cnt_q [NUM_CH];
  logic [7:0]           lock_cnt_d [NUM_CH];
  logic [DIV_WIDTH-1:0] div_cnt_q [NUM_CH];
  logic [DIV_WIDTH-1:0] div_cnt_d [NUM_CH];
  logic [NUM_CH-1:0]    locked_q, locked_d;
  logic [NUM_CH-1:0]    clk_en_q, clk_en_d;
  logic [NUM_CH-1:0]    div_wr;
  logic                 wr_en;
  logic [31:0]          rd_val;
  logic                 unused_bus_bits;

  assign unused_bus_bits = ^{bus.i_hsize, bus.i_haddr, bus.i_hwdata};

  assign bus.o_hreadyout = 1'b1;
  assign bus.o_hresp     = 1'b0;
  assign o_clk_en        = clk_en_q;
  assign o_locked        = locked_q;

  always_comb begin
    addr_valid_d = bus.i_hselx & bus.i_htrans[1] & bus.i_hready;
    addr_write_d = bus.i_hwrite;
    addr_idx_d   = bus.i_haddr[7:2];
  end

  always_comb begin
    wr_en  = addr_valid_q & addr_write_q;
    ctrl_d = ctrl_q;
    div_wr = '0;
    if (wr_en && addr_idx_q == 6'd0) ctrl_d = bus.i_hwdata[NUM_CH-1:0];
    for (int k = 0; k < NUM_CH; k++) begin
      div_d[k] = div_q[k];
      if (wr_en && addr_idx_q == 6'(4 + k)) begin
        div_d[k]  = bus.i_hwdata[DIV_WIDTH-1:0];
        div_wr[k] = 1'b1;
      end
    end
  end

  // Disable wins; an enable edge or any divider write while enabled restarts the lock timer.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      state_d[k]    = state_q[k];
      lock_cnt_d[k] = lock_cnt_q[k];
      div_cnt_d[k]  = div_cnt_q[k];
      if (ctrl_q[k] && !ctrl_d[k]) begin
        state_d[k]    = ST_OFF;
        lock_cnt_d[k] = '0;
        div_cnt_d[k]  = '0;
      end else if ((!ctrl_q[k] && ctrl_d[k]) || (ctrl_q[k] && div_wr[k])) begin
        state_d[k]    = ST_SETTLE;
        lock_cnt_d[k] = LOCK_INIT;
        div_cnt_d[k]  = '0;
      end else begin
        case (state_q[k])
          ST_SETTLE: begin
            if (lock_cnt_q[k] <= 8'd1) begin
              state_d[k]    = ST_RUN;
              lock_cnt_d[k] = '0;
              div_cnt_d[k]  = '0;
            end else begin
              lock_cnt_d[k] = lock_cnt_q[k] - 8'd1;
            end
          end
          ST_RUN: begin
            div_cnt_d[k] = (div_cnt_q[k] == div_q[k]) ? '0 : div_cnt_q[k] + DIV_WIDTH'(1);
          end
          default: ;
        endcase
      end
      locked_d[k] = (state_d[k] == ST_RUN);
      clk_en_d[k] = (state_d[k] == ST_RUN) && (div_cnt_d[k] == div_d[k]);
    end
  end

`ifdef CLKEN_IRQ_EN
  logic [NUM_CH-1:0] irq_q, irq_d;
  logic              irq_out_q;

  assign o_irq = irq_out_q;

  // A lock event in the same cycle as a W1C clear keeps the bit set.
  always_comb begin
    irq_d = irq_q;
    if (wr_en && addr_idx_q == 6'd2) irq_d = irq_q & ~bus.i_hwdata[NUM_CH-1:0];
    for (int k = 0; k < NUM_CH; k++) begin
      if (state_q[k] == ST_SETTLE && state_d[k] == ST_RUN) irq_d[k] = 1'b1;
    end
  end

  always_ff @(posedge i_clk_ahb) begin
    if (i_rst_ahb) begin
      irq_q     <= '0;
      irq_out_q <= 1'b0;
    end else begin
      irq_q     <= irq_d;
      irq_out_q <= |irq_d;
    end
  end
`endif

  always_comb begin
    rd_val = '0;
    case (addr_idx_q)
      6'd0: rd_val = 32'(ctrl_q);
      6'd1: rd_val = 32'(locked_q);
`ifdef CLKEN_IRQ_EN
      6'd2: rd_val = 32'(irq_q);
`endif
      default: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (addr_idx_q == 6'(4 + k)) rd_val = 32'(div_q[k]);
        end
      end
    endcase
    bus.o_hrdata = (addr_valid_q && !addr_write_q && !i_rst_ahb) ? rd_val : 32'd0;
  end

  always_ff @(posedge i_clk_ahb) begin
    if (i_rst_ahb) begin
      addr_valid_q <= 1'b0;
      addr_write_q <= 1'b0;
      addr_idx_q   <= '0;
      ctrl_q       <= '0;
      locked_q     <= '0;
      clk_en_q     <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        div_q[k]      <= '0;
        state_q[k]    <= ST_OFF;
        lock_cnt_q[k] <= '0;
        div_cnt_q[k]  <= '0;
      end
    end else begin
      addr_valid_q <= addr_valid_d;
      addr_write_q <= addr_write_d;
      addr_idx_q   <= addr_idx_d;
      ctrl_q       <= ctrl_d;
      locked_q     <= locked_d;
      clk_en_q     <= clk_en_d;
      for (int k = 0; k < NUM_CH; k++) begin
        div_q[k]      <= div_d[k];
        state_q[k]    <= state_d[k];
        lock_cnt_q[k] <= lock_cnt_d[k];
        div_cnt_q[k]  <= div_cnt_d[k];
      end
    end
  end

endmodule

// File: tb/tb_ahb_clk_en_gen.sv
// Directed bench for ahb_clk_en_gen (default parameters); the interrupt scenario
// is compiled only when CLKEN_IRQ_EN is defined.
module tb_ahb_clk_en_gen;

  logic       clk;
  logic       rst;
  logic [3:0] clk_en;
  logic [3:0] locked;
`ifdef CLKEN_IRQ_EN
  logic       irq;
`endif
  int         total;
  int         bad;

  ahb_clk_en_gen_if bus_if ();

  ahb_clk_en_gen #(.NUM_CH(4), .DIV_WIDTH(8), .LOCK_CYCLES(16)) dut (
    .i_clk_ahb (clk),
    .i_rst_ahb (rst),
    .bus       (bus_if),
    .o_clk_en  (clk_en),
`ifdef CLKEN_IRQ_EN
    .o_irq     (irq),
`endif
    .o_locked  (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    bus_if.i_hselx  = 1'b1;
    bus_if.i_htrans = 2'b10;
    bus_if.i_hwrite = 1'b1;
    bus_if.i_haddr  = addr;
    @(posedge clk); #1;
    bus_if.i_hselx  = 1'b0;
    bus_if.i_htrans = 2'b00;
    bus_if.i_hwrite = 1'b0;
    bus_if.i_hwdata = data;
    @(posedge clk); #1;
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic rdy, output logic resp);
    @(posedge clk); #1;
    bus_if.i_hselx  = 1'b1;
    bus_if.i_htrans = 2'b10;
    bus_if.i_hwrite = 1'b0;
    bus_if.i_haddr  = addr;
    @(posedge clk); #1;
    bus_if.i_hselx  = 1'b0;
    bus_if.i_htrans = 2'b00;
    #4;
    data = bus_if.o_hrdata;
    rdy  = bus_if.o_hreadyout;
    resp = bus_if.o_hresp;
  endtask

  task automatic wait_lock(input int ch, output int cycles);
    cycles = 0;
    while (!locked[ch] && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (clk_en !== 4'h0) begin bad++; $display("[TB] FAIL reset_clk_en got=%h want=0", clk_en); end
    total++; if (locked !== 4'h0) begin bad++; $display("[TB] FAIL reset_locked got=%h want=0", locked); end
    total++; if (bus_if.o_hrdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_hrdata got=%h want=0", bus_if.o_hrdata); end
    total++; if ({bus_if.o_hreadyout, bus_if.o_hresp} !== 2'b10) begin bad++; $display("[TB] FAIL reset_resp got=%b want=10", {bus_if.o_hreadyout, bus_if.o_hresp}); end
    rst = 1'b0;
  endtask

  task automatic test_div_zero();
    logic [31:0] d;
    logic        r, e;
    int          n;
    logic        all_on;
    ahb_write(32'h14, 32'h0);
    ahb_write(32'h00, 32'h2);
    wait_lock(1, n);
    total++; if (n !== 16) begin bad++; $display("[TB] FAIL div0_lock_cycles got=%0d want=16", n); end
    all_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (clk_en[1] !== 1'b1) all_on = 1'b0;
      @(posedge clk); #1;
    end
    total++; if (all_on !== 1'b1) begin bad++; $display("[TB] FAIL div0_constant got=0 want=1"); end
    ahb_read(32'h04, d, r, e);
    total++; if (d !== 32'h2) begin bad++; $display("[TB] FAIL status_ch1 got=%h want=2", d); end
    ahb_read(32'h00, d, r, e);
    total++; if (d !== 32'h2) begin bad++; $display("[TB] FAIL ctrl_read got=%h want=2", d); end
  endtask

  task automatic test_div3_lock();
    logic [31:0] d;
    logic        r, e;
    int          n;
    ahb_write(32'h10, 32'h3);
    ahb_write(32'h00, 32'h3);
    total++; if ({locked[1], clk_en[1]} !== 2'b11) begin bad++; $display("[TB] FAIL ch1_undisturbed got=%b want=11", {locked[1], clk_en[1]}); end
    wait_lock(0, n);
    total++; if (n !== 16) begin bad++; $display("[TB] FAIL div3_lock_cycles got=%0d want=16", n); end
    for (int c = 1; c <= 12; c++) begin
      total++;
      if (clk_en[0] !== ((c % 4) == 0)) begin
        bad++; $display("[TB] FAIL div3_pulse run_cycle=%0d got=%b want=%b", c, clk_en[0], (c % 4) == 0);
      end
      @(posedge clk); #1;
    end
    ahb_read(32'h10, d, r, e);
    total++; if (d !== 32'h3) begin bad++; $display("[TB] FAIL div0_read got=%h want=3", d); end
  endtask

  task automatic test_same_value_rewrite();
    int   n;
    logic quiet;
    ahb_write(32'h10, 32'h3);
    quiet = 1'b1;
    n = 0;
    while (!locked[0] && n < 40) begin
      if (clk_en[0] !== 1'b0) quiet = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    total++; if (n !== 16) begin bad++; $display("[TB] FAIL rewrite_relock got=%0d want=16", n); end
    total++; if (quiet !== 1'b1) begin bad++; $display("[TB] FAIL rewrite_quiet got=0 want=1"); end
    for (int c = 1; c <= 8; c++) begin
      total++;
      if (clk_en[0] !== ((c % 4) == 0)) begin
        bad++; $display("[TB] FAIL rewrite_resume run_cycle=%0d got=%b want=%b", c, clk_en[0], (c % 4) == 0);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_channel_off();
    int n;
    n = 0;
    while (!clk_en[0] && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    total++; if (clk_en[0] !== 1'b1) begin bad++; $display("[TB] FAIL off_find_pulse got=0 want=1"); end
    ahb_write(32'h00, 32'h1);
    total++; if ({locked[1], clk_en[1]} !== 2'b00) begin bad++; $display("[TB] FAIL ch1_off got=%b want=00", {locked[1], clk_en[1]}); end
    for (int j = 3; j <= 10; j++) begin
      total++;
      if (clk_en[0] !== ((j % 4) == 0)) begin
        bad++; $display("[TB] FAIL ch0_phase offset=%0d got=%b want=%b", j, clk_en[0], (j % 4) == 0);
      end
      @(posedge clk); #1;
    end
    total++; if (locked !== 4'b0001) begin bad++; $display("[TB] FAIL off_locked got=%b want=0001", locked); end
  endtask

  task automatic test_reset_mid_settle();
    logic [31:0] d;
    logic        r, e;
    logic        saw_lock;
    ahb_write(32'h00, 32'h2);
    repeat (5) @(posedge clk);
    #1;
    total++; if (locked !== 4'h0) begin bad++; $display("[TB] FAIL settle_locked got=%b want=0", locked); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    saw_lock = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (locked !== 4'h0) saw_lock = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (saw_lock !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_lock got=1 want=0"); end
    ahb_read(32'h00, d, r, e);
    total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL post_reset_ctrl got=%h want=0", d); end
    ahb_read(32'h10, d, r, e);
    total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL post_reset_div0 got=%h want=0", d); end
    ahb_read(32'h14, d, r, e);
    total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL post_reset_div1 got=%h want=0", d); end
    ahb_read(32'h3C, d, r, e);
    total++; if ({d, r, e} !== {32'h0, 2'b10}) begin bad++; $display("[TB] FAIL read_3c got=%h rdy=%b resp=%b want=0 rdy=1 resp=0", d, r, e); end
    // Reset on the address-accept edge must drop the pending write.
    @(posedge clk); #1;
    bus_if.i_hselx  = 1'b1;
    bus_if.i_htrans = 2'b10;
    bus_if.i_hwrite = 1'b1;
    bus_if.i_haddr  = 32'h0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_if.i_hselx  = 1'b0;
    bus_if.i_htrans = 2'b00;
    bus_if.i_hwrite = 1'b0;
    bus_if.i_hwdata = 32'h1;
    ahb_read(32'h00, d, r, e);
    total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL discard_pending got=%h want=0", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic        r, e;
    ahb_write(32'h04, 32'hF);
    ahb_read(32'h04, d, r, e);
    total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL status_write got=%h want=0", d); end
    ahb_write(32'h3C, 32'hFFFF);
    ahb_read(32'h3C, d, r, e);
    total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL unmapped_write got=%h want=0", d); end
    ahb_write(32'h20, 32'h5);
    ahb_read(32'h20, d, r, e);
    total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL div4_absent got=%h want=0", d); end
    ahb_write(32'h00, 32'hF0);
    ahb_read(32'h00, d, r, e);
    total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL ctrl_upper_bits got=%h want=0", d); end
    ahb_write(32'h10, 32'h1FF);
    ahb_read(32'h10, d, r, e);
    total++; if (d !== 32'hFF) begin bad++; $display("[TB] FAIL div_trunc got=%h want=ff", d); end
    ahb_read(32'h08, d, r, e);
    total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL irq_reg_idle got=%h want=0", d); end
  endtask

`ifdef CLKEN_IRQ_EN
  task automatic test_irq();
    logic [31:0] d;
    logic        r, e;
    int          n;
    ahb_write(32'h18, 32'h1);
    ahb_write(32'h00, 32'h4);
    wait_lock(2, n);
    total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_on_lock got=%b want=1", irq); end
    ahb_read(32'h08, d, r, e);
    total++; if (d !== 32'h4) begin bad++; $display("[TB] FAIL irq_reg got=%h want=4", d); end
    ahb_write(32'h08, 32'h4);
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_clear got=%b want=0", irq); end
    ahb_write(32'h18, 32'h1);
    repeat (13) @(posedge clk);
    ahb_write(32'h08, 32'h4);
    total++; if ({locked[2], irq} !== 2'b11) begin bad++; $display("[TB] FAIL irq_set_wins got=%b want=11", {locked[2], irq}); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus_if.i_hselx  = 1'b0;
    bus_if.i_hready = 1'b1;
    bus_if.i_htrans = 2'b00;
    bus_if.i_hwrite = 1'b0;
    bus_if.i_haddr  = 32'h0;
    bus_if.i_hsize  = 3'b010;
    bus_if.i_hwdata = 32'h0;
    test_reset();
    test_div_zero();
    test_div3_lock();
    test_same_value_rewrite();
    test_channel_off();
    test_reset_mid_settle();
    test_unmapped();
`ifdef CLKEN_IRQ_EN
    test_irq();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
